scan_regfile: RTL and testbench
===============================

// Module: scan_regfile
// PURPOSE
// - Bank of NREGS registers, each WIDTH bits wide, with one write/modify port and two combinational read ports.
// - All registers form a single scan chain for test and config load/unload. Successor to the single-register scan shifter.
// - The write port also applies an in-place shift/rotate to the addressed register.
// - Sits beside the datapath as the architectural register store. Scan chain is daisy-chained with the other scan blocks.
// PARAMETERS
// - WIDTH  8  bits per register; >=1
// - NREGS  4  number of registers; >=1; need not be a power of two
// - AW     $clog2(NREGS) (min 1)  address width; derived, not overridden
// PORTS
// - clk          in   1            single clock, rising edge
// - rst          in   1            synchronous, active-high reset
// - scan_enable  in   1            1 = whole bank shifts as one chain; overrides the write port
// - scan_in      in   1            serial chain input
// - scan_out     out  1            serial chain output = MSB of reg[NREGS-1]
// - scan_wrap    out  1            registered 1-cycle pulse after every NREGS*WIDTH scan shifts
// - we           in   1            write/modify strobe
// - op           in   2            0 LOAD, 1 SHL, 2 SHR, 3 ROL (applied to reg[waddr])
// - waddr        in   AW           target register
// - wdata        in   WIDTH        LOAD data
// - shift_in     in   1            bit inserted by SHL/SHR
// - raddr_a/b    in   AW           read addresses
// - rdata_a/b    out  WIDTH        combinational read data
// BEHAVIOUR
// Reset
// - All regs = 0, scan count = 0, scan_wrap = 0. Hence scan_out = 0 and rdata = 0 the cycle after rst.
// Priority per cycle: rst > scan_enable > we.
// Scan (scan_enable=1), one shift per cycle
// - Chain vector is {reg[NREGS-1],...,reg[0]}, shifted left. scan_in enters reg[0][0].
// - reg[i][WIDTH-1] feeds reg[i+1][0]. Total chain length NREGS*WIDTH.
// - we is ignored while scanning.
// - Scan counter counts 0..NREGS*WIDTH-1 and wraps to 0.
// - scan_wrap=1 in the cycle after the shift that wraps the counter; otherwise 0.
// - Counter holds when scan_enable=0. rst clears it, including mid-scan.
// Write (scan_enable=0, we=1), result visible next cycle
// - LOAD: reg = wdata.
// - SHL: reg = {reg[WIDTH-2:0], shift_in}.
// - SHR: reg = {shift_in, reg[WIDTH-1:1]}.
// - ROL: reg = {reg[WIDTH-2:0], reg[WIDTH-1]}.
// - WIDTH=1: SHL and SHR give shift_in; ROL holds.
// - waddr >= NREGS: no register changes.
// - we=0 or op not applied: all registers hold.
// Reads
// - rdata_x = reg[raddr_x] combinationally; raddr_x >= NREGS returns 0.
// - Same-cycle read of the address being written returns the OLD value (no bypass).
// - raddr_a == raddr_b is legal; both ports return the same data.
// Simultaneous events
// - rst with scan_enable or we: reset wins.
// - scan_enable with we: scan wins; the write is dropped, not deferred.
// STRUCTURE
// - Package scan_regfile_pkg: op encodings OP_LOAD=2'd0, OP_SHL=2'd1, OP_SHR=2'd2, OP_ROL=2'd3; op_t typedef.
// - Sub-module scan_regfile_word:
//   - One WIDTH register with rst, scan shift (sin/sout) and a write-enable/op next-state mux.
//   - Instantiated NREGS times via generate; chain wired sout[i] -> sin[i+1].
// - Top level holds the address decode, read muxes and scan counter.
// TESTING
// 1. Reset, then read all regs; check scan_out.
//    -> every rdata = 0, scan_out = 0, scan_wrap = 0.
// 2. LOAD 8'hA5 to r1, 8'h3C to r2; read a=1, b=2 next cycle.
//    -> rdata_a = A5, rdata_b = 3C. A read of r1 in the write cycle still shows 00.
// 3. r0 = 8'h81, then apply SHL(shift_in=0), SHR(shift_in=1), ROL in order.
//    -> r0 = 02, then 81, then 03.
// 4. Defaults (32 bits): scan in 0xDEADBEEF MSB-first over 32 cycles, then read.
//    -> r3 = DE, r2 = AD, r1 = BE, r0 = EF.
//    -> scan_wrap pulses exactly once, in cycle 33.
//    -> A further 32 shifts of 0 return scan_out = 1,1,0,1,1,1,1,0,... (MSB-first DEADBEEF).
// 5. Conflicts: scan_enable=1 with we=1, LOAD FF to r0 -> r0 gets the scan bit, not FF.
//    - waddr=5 with NREGS=5 -> no register changes.
//    - raddr=7 -> 0.
// 6. Reset mid-scan (after 10 shifts), then 32 shifts.
//    -> all regs 0 after reset; scan_wrap fires on the 32nd shift after reset, not the 22nd.

Source files
------------

// File: rtl/scan_regfile_pkg.sv
// Shared definitions for the scan register file: write-port operation encodings.
package scan_regfile_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_SHL  = 2'd1,
    OP_SHR  = 2'd2,
    OP_ROL  = 2'd3
  } op_t;

endpackage

// File: rtl/scan_regfile_word.sv
// One register of the bank: scan shift has priority over the write/modify port.
module scan_regfile_word
  import scan_regfile_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_enable,
  input  logic             sin,
  input  logic             we,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] wdata,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Shifts are built as shift-then-patch so WIDTH=1 degenerates correctly:
  // SHL/SHR yield shift_in and ROL holds.
  always_comb begin
    q_d = q_q;
    if (scan_enable) begin
      q_d    = q_q << 1;
      q_d[0] = sin;
    end else if (we) begin
      case (op_t'(op))
        OP_LOAD: q_d = wdata;
        OP_SHL: begin
          q_d    = q_q << 1;
          q_d[0] = shift_in;
        end
        OP_SHR: begin
          q_d            = q_q >> 1;
          q_d[WIDTH-1]   = shift_in;
        end
        OP_ROL: begin
          q_d    = q_q << 1;
          q_d[0] = q_q[WIDTH-1];
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign sout = q_q[WIDTH-1];

endmodule

// File: rtl/scan_regfile.sv
// Register bank with one write/modify port, two combinational read ports and a
// single scan chain through all registers, reg[0] nearest scan_in.
module scan_regfile
  import scan_regfile_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter int   NREGS = 4,
  localparam int  AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_enable,
  input  logic             scan_in,
  output logic             scan_out,
  output logic             scan_wrap,
  input  logic             we,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             shift_in,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  localparam int CHAIN = NREGS * WIDTH;
  localparam int CW    = (CHAIN > 1) ? $clog2(CHAIN) : 1;

  logic [WIDTH-1:0] regs [NREGS];
  logic             sout [NREGS];
  logic [NREGS-1:0] we_vec;

  // Out-of-range write addresses match no word, so nothing changes.
  always_comb begin
    we_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      we_vec[i] = we && (waddr == AW'(i));
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_word
    logic sin;
    if (i == 0) begin : g_head
      assign sin = scan_in;
    end else begin : g_link
      assign sin = sout[i-1];
    end

    scan_regfile_word #(.WIDTH(WIDTH)) u_word (
      .clk         (clk),
      .rst         (rst),
      .scan_enable (scan_enable),
      .sin         (sin),
      .we          (we_vec[i]),
      .op          (op),
      .wdata       (wdata),
      .shift_in    (shift_in),
      .q           (regs[i]),
      .sout        (sout[i])
    );
  end

  assign scan_out = sout[NREGS-1];

  // Reads return the registered value; an address past the bank reads as zero.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (raddr_a == AW'(i)) rdata_a = regs[i];
      if (raddr_b == AW'(i)) rdata_b = regs[i];
    end
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          scan_wrap_q;
  logic          scan_wrap_d;
  logic          wrap_hit;

  assign wrap_hit = (cnt_q == CW'(CHAIN - 1));

  always_comb begin
    cnt_d       = cnt_q;
    scan_wrap_d = 1'b0;
    if (scan_enable) begin
      cnt_d       = wrap_hit ? '0 : cnt_q + 1'b1;
      scan_wrap_d = wrap_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      scan_wrap_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_scan_regfile.sv
// Directed bench for scan_regfile: default 4x8 bank plus a 5-entry bank for
// out-of-range address behaviour.
module tb_scan_regfile;

  logic       clk;
  logic       rst;
  logic       scan_enable;
  logic       scan_in;
  logic       scan_out;
  logic       scan_wrap;
  logic       we;
  logic [1:0] op;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic       shift_in;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;

  logic       s5_se;
  logic       s5_si;
  logic       s5_so;
  logic       s5_wrap;
  logic       s5_we;
  logic [1:0] s5_op;
  logic [2:0] s5_waddr;
  logic [7:0] s5_wdata;
  logic       s5_shin;
  logic [2:0] s5_raddr_a;
  logic [2:0] s5_raddr_b;
  logic [7:0] s5_rdata_a;
  logic [7:0] s5_rdata_b;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  scan_regfile #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst(rst), .scan_enable(scan_enable), .scan_in(scan_in),
    .scan_out(scan_out), .scan_wrap(scan_wrap), .we(we), .op(op),
    .waddr(waddr), .wdata(wdata), .shift_in(shift_in),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b)
  );

  scan_regfile #(.WIDTH(8), .NREGS(5)) dut5 (
    .clk(clk), .rst(rst), .scan_enable(s5_se), .scan_in(s5_si),
    .scan_out(s5_so), .scan_wrap(s5_wrap), .we(s5_we), .op(s5_op),
    .waddr(s5_waddr), .wdata(s5_wdata), .shift_in(s5_shin),
    .raddr_a(s5_raddr_a), .raddr_b(s5_raddr_b), .rdata_a(s5_rdata_a), .rdata_b(s5_rdata_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic write_reg(input logic [1:0] o, input logic [1:0] a,
                           input logic [7:0] d, input logic si);
    we = 1'b1; op = o; waddr = a; wdata = d; shift_in = si;
    tick();
    we = 1'b0;
  endtask

  task automatic write5(input logic [2:0] a, input logic [7:0] d);
    s5_we = 1'b1; s5_op = 2'd0; s5_waddr = a; s5_wdata = d;
    tick();
    s5_we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
    raddr_a = a; raddr_b = a;
    #1;
    check({tag, "_a"}, 32'(rdata_a), 32'(exp));
    check({tag, "_b"}, 32'(rdata_b), 32'(exp));
  endtask

  task automatic read5_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    s5_raddr_a = a; s5_raddr_b = a;
    #1;
    check({tag, "_a"}, 32'(s5_rdata_a), 32'(exp));
    check({tag, "_b"}, 32'(s5_rdata_b), 32'(exp));
  endtask

  task automatic scan_shift(input logic b);
    scan_enable = 1'b1; scan_in = b;
    tick();
    scan_enable = 1'b0;
  endtask

  logic [31:0] pattern;
  logic [7:0]  r_exp [4];

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; scan_enable = 1'b0; scan_in = 1'b0; we = 1'b0; op = 2'd0;
    waddr = '0; wdata = '0; shift_in = 1'b0; raddr_a = '0; raddr_b = '0;
    s5_se = 1'b0; s5_si = 1'b0; s5_we = 1'b0; s5_op = 2'd0; s5_waddr = '0;
    s5_wdata = '0; s5_shin = 1'b0; s5_raddr_a = '0; s5_raddr_b = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    for (int i = 0; i < 4; i++) read_check($sformatf("rst_r%0d", i), 2'(i), 8'h00);
    check("rst_scan_out", 32'(scan_out), 32'd0);
    check("rst_scan_wrap", 32'(scan_wrap), 32'd0);

    // LOAD, with a same-cycle read showing the old value
    we = 1'b1; op = 2'd0; waddr = 2'd1; wdata = 8'hA5; raddr_a = 2'd1;
    #1;
    check("wr_cycle_old", 32'(rdata_a), 32'h00);
    tick();
    waddr = 2'd2; wdata = 8'h3C;
    tick();
    we = 1'b0;
    raddr_a = 2'd1; raddr_b = 2'd2;
    #1;
    check("load_r1", 32'(rdata_a), 32'hA5);
    check("load_r2", 32'(rdata_b), 32'h3C);

    // we=0 holds even with a different LOAD presented
    op = 2'd0; waddr = 2'd1; wdata = 8'h55;
    tick();
    read_check("hold_r1", 2'd1, 8'hA5);

    // SHL, SHR, ROL on r0
    write_reg(2'd0, 2'd0, 8'h81, 1'b0);
    write_reg(2'd1, 2'd0, 8'h00, 1'b0);
    read_check("shl", 2'd0, 8'h02);
    write_reg(2'd2, 2'd0, 8'h00, 1'b1);
    read_check("shr", 2'd0, 8'h81);
    write_reg(2'd3, 2'd0, 8'h00, 1'b0);
    read_check("rol", 2'd0, 8'h03);

    // scan in DEADBEEF MSB first; wrap pulses only after the 32nd shift
    pattern = 32'hDEADBEEF;
    for (int k = 0; k < 32; k++) begin
      scan_shift(pattern[31-k]);
      check($sformatf("wrap_in_%0d", k), 32'(scan_wrap), (k == 31) ? 32'd1 : 32'd0);
    end
    tick();
    check("wrap_cleared", 32'(scan_wrap), 32'd0);
    r_exp[3] = 8'hDE; r_exp[2] = 8'hAD; r_exp[1] = 8'hBE; r_exp[0] = 8'hEF;
    for (int i = 0; i < 4; i++) read_check($sformatf("scan_r%0d", i), 2'(i), r_exp[i]);

    // scan out with zeros, checked against a queue of expected bits
    for (int k = 31; k >= 0; k--) exp_q.push_back(32'(pattern[k]));
    for (int k = 0; k < 32; k++) begin
      check($sformatf("scan_out_%0d", k), 32'(scan_out), exp_q.pop_front());
      scan_shift(1'b0);
      check($sformatf("wrap_out_%0d", k), 32'(scan_wrap), (k == 31) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) read_check($sformatf("drained_r%0d", i), 2'(i), 8'h00);

    // scan beats a simultaneous write, which is dropped
    we = 1'b1; op = 2'd0; waddr = 2'd0; wdata = 8'hFF;
    scan_shift(1'b1);
    we = 1'b0;
    read_check("scan_wins", 2'd0, 8'h01);
    tick();
    read_check("no_deferred_wr", 2'd0, 8'h01);

    // out-of-range write/read on the 5-entry bank
    write5(3'd4, 8'h77);
    write5(3'd0, 8'h11);
    write5(3'd5, 8'hFF);
    write5(3'd6, 8'hFF);
    write5(3'd7, 8'hFF);
    read5_check("n5_r0", 3'd0, 8'h11);
    read5_check("n5_r1", 3'd1, 8'h00);
    read5_check("n5_r2", 3'd2, 8'h00);
    read5_check("n5_r3", 3'd3, 8'h00);
    read5_check("n5_r4", 3'd4, 8'h77);
    read5_check("n5_rd5", 3'd5, 8'h00);
    read5_check("n5_rd7", 3'd7, 8'h00);

    // reset mid-scan (with scan and write also asserted) restarts the count
    for (int k = 0; k < 10; k++) scan_shift(k[0]);
    rst = 1'b1; scan_enable = 1'b1; scan_in = 1'b1;
    we = 1'b1; op = 2'd0; waddr = 2'd3; wdata = 8'hFF;
    tick();
    rst = 1'b0; scan_enable = 1'b0; we = 1'b0;
    for (int i = 0; i < 4; i++) read_check($sformatf("rst2_r%0d", i), 2'(i), 8'h00);
    check("rst2_wrap", 32'(scan_wrap), 32'd0);
    check("rst2_scan_out", 32'(scan_out), 32'd0);
    for (int k = 0; k < 32; k++) begin
      scan_shift(1'b0);
      check($sformatf("wrap_rst_%0d", k), 32'(scan_wrap), (k == 31) ? 32'd1 : 32'd0);
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
